usr_sequencer: RTL and testbench
================================

USR_SEQUENCER -- requirements
Module: usr_sequencer

Interface
REQ-001 Parameter DW, default 4: datapath width; SHALL equal the width of the shift register being sequenced.
REQ-002 Parameter CW, default 3: shift-count width; SHALL support maximum count 2^CW-1.
REQ-003 clk  input  1  single clock; all flops SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  sequencer can accept a command this cycle.
REQ-007 cmd_op  input  2  00 LOAD, 01 SHIFT (fill from cmd_fill), 10 ROTATE (fill from sr_q MSB), 11 MSBSET.
REQ-008 cmd_count  input  CW  number of shift cycles for SHIFT/ROTATE; ignored for LOAD/MSBSET.
REQ-009 cmd_data  input  DW  parallel load value for LOAD.
REQ-010 cmd_fill  input  1  serial bit for SHIFT/MSBSET.
REQ-011 cmd_abort  input  1  terminate the active command.
REQ-012 sr_q  input  DW  current shift-register contents (feedback).
REQ-013 sr_mode  output  2  shift-register mode: 00 hold, 01 MSB insert, 10 shift toward MSB with LSB insert, 11 parallel load.
REQ-014 sr_in  output  1  serial bit to shift register.
REQ-015 sr_din  output  DW  parallel data to shift register.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle pulse at command completion.
REQ-018 aborted  output  1  one-cycle pulse, coincident with done, when the command was aborted.

Function
REQ-019 States SHALL be IDLE, LOAD, SHIFT, MSB, DONE; encoding is free.
REQ-020 cmd_ready SHALL be 1 only in IDLE and not during rst; handshake = cmd_valid & cmd_ready at a rising edge.
REQ-021 On accept, cmd_op, cmd_count, cmd_data and cmd_fill SHALL be captured; later changes to these inputs SHALL have no effect.
REQ-022 LOAD: one cycle in LOAD with sr_mode=11 and sr_din=captured data, then DONE.
REQ-023 MSBSET: one cycle in MSB with sr_mode=01 and sr_in=captured fill, then DONE.
REQ-024 SHIFT: exactly cmd_count consecutive cycles in SHIFT with sr_mode=10 and sr_in=captured fill, then DONE.
REQ-025 ROTATE: same timing as SHIFT; sr_in SHALL equal sr_q[DW-1] combinationally in every SHIFT cycle.
REQ-026 SHIFT/ROTATE with cmd_count=0: SHALL go directly to DONE with no shift cycle; sr_mode stays 00.
REQ-027 Latency: command accepted at edge E; first active cycle starts at E; done high in the cycle after the last active cycle; IDLE (cmd_ready=1) in the cycle after done.
REQ-028 In IDLE and DONE, sr_mode SHALL be 00, sr_in 0, sr_din 0.
REQ-029 cmd_abort high in LOAD, MSB or SHIFT at an edge SHALL move the state to DONE with done=1 and aborted=1; the cycle in which abort was sampled still counts as an active cycle.
REQ-030 cmd_abort in IDLE or DONE SHALL be ignored; cmd_abort together with cmd_valid in IDLE: command accepted, abort ignored.
REQ-031 Abort in the last active cycle SHALL still assert aborted.
REQ-032 Internal shift counter SHALL be CW bits and never wrap; maximum count 2^CW-1 SHALL give exactly 2^CW-1 shift cycles.
REQ-033 No back-to-back acceptance: minimum spacing between accepts is active cycles + 2.

Reset
REQ-034 rst high at an edge SHALL force IDLE, sr_mode=00, sr_in=0, sr_din=0, busy=0, done=0, aborted=0, counter=0, overriding any command or abort.
REQ-035 After rst deasserts, cmd_ready SHALL be 1 in the first cycle.
REQ-036 Reset mid-command SHALL discard the command without a done pulse.

Verification
REQ-037 LOAD, cmd_data=4'b1010 -> one cycle sr_mode=11, sr_din=1010; done next cycle; sr_q=1010.
REQ-038 SHIFT, count=3, fill=1, sr_q starting 0000 -> three cycles sr_mode=10; sr_q=0111; done one cycle later.
REQ-039 ROTATE, count=4, sr_q starting 1001 -> four shift cycles; sr_q returns to 1001; sr_in tracks sr_q[3].
REQ-040 SHIFT, count=5, cmd_abort in the 2nd active cycle -> exactly 2 shift cycles; done=aborted=1 next cycle.
REQ-041 SHIFT, count=0 -> no sr_mode=10 cycle; done at the cycle after accept; cmd_ready back the cycle after that.
REQ-042 rst asserted in the 3rd cycle of SHIFT count=7 -> next cycle IDLE, all outputs 0, no done pulse, cmd_ready=1 after release.

Source files
------------

// File: rtl/usr_sequencer_if.sv
// usr_sequencer_if: command handshake and shift-register control bundle for usr_sequencer
//   cmd_*   : command request/accept, opcode, shift count, load data, serial fill, abort
//   sr_*    : shift-register feedback (sr_q) and control (sr_mode, sr_in, sr_din)
//   busy/done/aborted : sequencer status
interface usr_sequencer_if #(parameter int DW = 4, parameter int CW = 3);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [CW-1:0] cmd_count;
   logic [DW-1:0] cmd_data;
   logic          cmd_fill;
   logic          cmd_abort;
   logic [DW-1:0] sr_q;
   logic [1:0]    sr_mode;
   logic          sr_in;
   logic [DW-1:0] sr_din;
   logic          busy;
   logic          done;
   logic          aborted;
   modport master (
      output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, cmd_abort, sr_q,
      input  cmd_ready, sr_mode, sr_in, sr_din, busy, done, aborted
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, cmd_abort, sr_q,
      output cmd_ready, sr_mode, sr_in, sr_din, busy, done, aborted
   );
endinterface

// File: rtl/usr_sequencer.sv
// usr_sequencer: sequences LOAD / SHIFT / ROTATE / MSBSET commands onto an external shift register
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : usr_sequencer_if slave -- command handshake in, shift-register control out, status out
module usr_sequencer #(
   parameter int DW = 4,
   parameter int CW = 3
) (
   input logic            clk,
   input logic            rst,
   usr_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, MSB, DONE} state_t;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [DW-1:0] data_q;
   logic          fill_q, rot_q, ab_q, ab_n, accept;
   assign accept = bus.cmd_valid & bus.cmd_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         data_q <= '0;
         fill_q <= 1'b0;
         rot_q  <= 1'b0;
         ab_q   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         ab_q  <= ab_n;
         if (accept) begin
            data_q <= bus.cmd_data;
            fill_q <= bus.cmd_fill;
            rot_q  <= bus.cmd_op == 2'b10;
         end
      end
   end
   // cnt holds the remaining shift cycles including the current one, so it only ever counts down to zero
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ab_n    = 1'b0;
      case (state)
         IDLE: if (accept) begin
            cnt_n   = bus.cmd_op[1] ^ bus.cmd_op[0] ? bus.cmd_count : '0;
            state_n = bus.cmd_op == 2'b00 ? LOAD :
                      bus.cmd_op == 2'b11 ? MSB  :
                      bus.cmd_count == '0 ? DONE : SHIFT;
         end
         LOAD, MSB: begin
            state_n = DONE;
            ab_n    = bus.cmd_abort;
         end
         SHIFT: begin
            cnt_n   = bus.cmd_abort ? '0 : cnt - 1'b1;
            ab_n    = bus.cmd_abort;
            state_n = bus.cmd_abort || cnt == CW'(1) ? DONE : SHIFT;
         end
         DONE: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      bus.cmd_ready = state == IDLE && !rst;
      bus.busy      = state != IDLE;
      bus.done      = state == DONE;
      bus.aborted   = state == DONE && ab_q;
      bus.sr_mode   = state == LOAD ? 2'b11 : state == MSB ? 2'b01 : state == SHIFT ? 2'b10 : 2'b00;
      bus.sr_in     = state == MSB ? fill_q : state == SHIFT ? (rot_q ? bus.sr_q[DW-1] : fill_q) : 1'b0;
      bus.sr_din    = state == LOAD ? data_q : '0;
   end
endmodule

// File: tb/tb_usr_sequencer.sv
// tb_usr_sequencer: table-driven scoreboard bench for usr_sequencer with a behavioural shift register
module tb_usr_sequencer;
   localparam int DW = 4;
   localparam int CW = 3;
   localparam int OW = DW + 7;
   typedef struct packed {
      logic          abort;
      logic [OW-1:0] out;
   } exp_t;
   typedef struct {
      logic [1:0]    op;
      logic [CW-1:0] cnt;
      logic [DW-1:0] data;
      logic [DW-1:0] init;
      logic [DW-1:0] fin;
      logic          fill;
      int            abort_at;
   } vec_t;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pre_en = 1'b0;
   logic [DW-1:0] pre_val = '0;
   logic [DW-1:0] sr;
   logic [OW-1:0] obs;
   int            n_cmp = 0;
   int            n_fail = 0;
   exp_t          q[$];
   vec_t          vecs[13];
   usr_sequencer_if #(.DW(DW), .CW(CW)) bus();
   usr_sequencer #(.DW(DW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [DW-1:0] sr_next(logic [DW-1:0] m, logic [1:0] mode, logic sin, logic [DW-1:0] din);
      return mode == 2'b11 ? din : mode == 2'b10 ? {m[DW-2:0], sin} : mode == 2'b01 ? {sin, m[DW-1:1]} : m;
   endfunction
   function automatic logic [OW-1:0] pk(logic rdy, logic bsy, logic dn, logic ab, logic [1:0] mode, logic sin, logic [DW-1:0] din);
      return {rdy, bsy, dn, ab, mode, sin, din};
   endfunction
   always @(posedge clk) sr <= pre_en ? pre_val : sr_next(sr, bus.sr_mode, bus.sr_in, bus.sr_din);
   assign bus.sr_q = sr;
   assign obs = pk(bus.cmd_ready, bus.busy, bus.done, bus.aborted, bus.sr_mode, bus.sr_in, bus.sr_din);
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (rdy,busy,done,ab,mode,in,din)", name, act[OW-1:0], exp[OW-1:0]);
      end
   endtask
   task automatic run_vec(int idx, vec_t v);
      logic [DW-1:0] m;
      int            n_act;
      int            cyc;
      exp_t          e;
      m     = v.init;
      n_act = (v.op == 2'd0 || v.op == 2'd3) ? 1 : int'(v.cnt);
      if (v.abort_at != 0 && v.abort_at < n_act) n_act = v.abort_at;
      for (int i = 1; i <= n_act; i++) begin
         e.abort = i == v.abort_at;
         e.out   = pk(1'b0, 1'b1, 1'b0, 1'b0,
                      v.op == 2'd0 ? 2'b11 : v.op == 2'd3 ? 2'b01 : 2'b10,
                      v.op == 2'd2 ? m[DW-1] : v.op == 2'd0 ? 1'b0 : v.fill,
                      v.op == 2'd0 ? v.data : '0);
         q.push_back(e);
         m = sr_next(m, e.out[DW+2:DW+1], e.out[DW], e.out[DW-1:0]);
      end
      q.push_back('{1'b1, pk(1'b0, 1'b1, 1'b1, v.abort_at != 0, 2'b00, 1'b0, '0)});
      q.push_back('{1'b1, pk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0)});
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = v.op;
      bus.cmd_count = v.cnt;
      bus.cmd_data  = v.data;
      bus.cmd_fill  = v.fill;
      pre_en        = 1'b1;
      pre_val       = v.init;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      pre_en        = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_count = CW'($urandom);
      bus.cmd_data  = DW'($urandom);
      bus.cmd_fill  = 1'($urandom);
      cyc = 0;
      while (q.size() > 0) begin
         e = q.pop_front();
         bus.cmd_abort = e.abort;
         @(negedge clk);
         check($sformatf("v%0d_c%0d", idx, cyc), 32'(obs), 32'(e.out));
         cyc++;
         if (q.size() > 0) begin
            @(posedge clk);
            #1;
         end
      end
      check($sformatf("v%0d_srq", idx), 32'(sr), 32'(v.fin));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      vecs[0]  = '{2'd0, 3'd0, 4'b1010, 4'b0000, 4'b1010, 1'b0, 0};
      vecs[1]  = '{2'd1, 3'd3, 4'b0000, 4'b0000, 4'b0111, 1'b1, 0};
      vecs[2]  = '{2'd2, 3'd4, 4'b0000, 4'b1001, 4'b1001, 1'b0, 0};
      vecs[3]  = '{2'd1, 3'd5, 4'b0000, 4'b0000, 4'b0011, 1'b1, 2};
      vecs[4]  = '{2'd1, 3'd0, 4'b0000, 4'b0101, 4'b0101, 1'b1, 0};
      vecs[5]  = '{2'd3, 3'd0, 4'b0000, 4'b0000, 4'b1000, 1'b1, 0};
      vecs[6]  = '{2'd3, 3'd0, 4'b0000, 4'b1111, 4'b0111, 1'b0, 0};
      vecs[7]  = '{2'd1, 3'd7, 4'b0000, 4'b0010, 4'b1111, 1'b1, 0};
      vecs[8]  = '{2'd2, 3'd7, 4'b0000, 4'b1001, 4'b1100, 1'b1, 0};
      vecs[9]  = '{2'd0, 3'd0, 4'b0110, 4'b0000, 4'b0110, 1'b0, 1};
      vecs[10] = '{2'd1, 3'd3, 4'b0000, 4'b1111, 4'b1000, 1'b0, 3};
      vecs[11] = '{2'd2, 3'd0, 4'b0000, 4'b1000, 4'b1000, 1'b1, 0};
      vecs[12] = '{2'd3, 3'd0, 4'b0000, 4'b0001, 4'b1000, 1'b1, 1};
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd1;
      bus.cmd_count = 3'd5;
      bus.cmd_data  = '0;
      bus.cmd_fill  = 1'b1;
      bus.cmd_abort = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_hold", 32'(obs), 32'(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0)));
      bus.cmd_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("reset_release", 32'(obs), 32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0)));
      for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd1;
      bus.cmd_count = 3'd7;
      bus.cmd_fill  = 1'b1;
      bus.cmd_abort = 1'b0;
      pre_en        = 1'b1;
      pre_val       = '0;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      pre_en        = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("midrst_shift%0d", i), 32'(obs), 32'(pk(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, '0)));
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("midrst_cleared", 32'(obs), 32'(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0)));
      rst = 1'b0;
      #1;
      check("midrst_ready", 32'(obs), 32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0)));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("midrst_no_done", 32'(obs), 32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0)));
      run_vec(13, vecs[1]);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
